// File: rtl/sd_to_apc_if.sv
// Bundle for the APC transmit endpoint: upstream srdy/drdy word port plus the
// phase-change launch signals toward the far clock domain.
interface sd_to_apc_if #(
    parameter int width = 32
);
    logic             c_srdy;
    logic             c_drdy;
    logic [width-1:0] c_data;
    logic             p_ph_send;
    logic             p_ph_ack;
    logic [width-1:0] p_data;

    modport master (
        output c_srdy, c_data, p_ph_ack,
        input  c_drdy, p_ph_send, p_data
    );

    modport slave (
        input  c_srdy, c_data, p_ph_ack,
        output c_drdy, p_ph_send, p_data
    );
endinterface

// File: rtl/sd_to_apc.sv
// Transmit end of the async phase-change link: one-entry holding register feeding
// a launch FSM that holds p_data, toggles p_ph_send and waits for the ack toggle.
module sd_to_apc #(
    parameter int width = 32
) (
    input  logic          clk,
    input  logic          reset,
    sd_to_apc_if.slave    bus
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_WAIT
    } state_t;

    state_t           r_state;
    logic [width-1:0] r_pend_data;
    logic             r_pend_valid;
    logic [width-1:0] r_p_data;
    logic             r_ph_send;
    logic             r_sync1;
    logic             r_sync2;
    logic             r_dly_ack;

    logic             w_ack_edge;
    logic             w_c_drdy;
    logic             w_xfer;

    assign w_ack_edge = r_sync2 ^ r_dly_ack;
    // In S_IDLE the pending word drains this cycle, so a refill is always safe.
    assign w_c_drdy   = !reset || !r_pend_valid || (r_state == S_IDLE);
    assign w_xfer     = bus.c_srdy && w_c_drdy;

    assign bus.c_drdy    = w_c_drdy;
    assign bus.p_data    = r_p_data;
    assign bus.p_ph_send = r_ph_send;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_pend_data  <= '0;
            r_pend_valid <= 1'b0;
            r_p_data     <= '0;
            r_ph_send    <= 1'b0;
            r_sync1      <= 1'b0;
            r_sync2      <= 1'b0;
            r_dly_ack    <= 1'b0;
        end else begin
            r_sync1   <= bus.p_ph_ack;
            r_sync2   <= r_sync1;
            // Tracks every cycle so an edge seen outside S_WAIT is consumed, not replayed.
            r_dly_ack <= r_sync2;

            if (w_xfer) begin
                r_pend_data  <= bus.c_data;
                r_pend_valid <= 1'b1;
            end else if ((r_state == S_IDLE) && r_pend_valid) begin
                r_pend_valid <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    if (r_pend_valid) begin
                        r_p_data <= r_pend_data;
                        r_state  <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    r_ph_send <= ~r_ph_send;
                    r_state   <= S_WAIT;
                end
                S_WAIT: begin
                    if (w_ack_edge) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sd_to_apc.sv
// Scoreboard bench for sd_to_apc: words are queued as they are accepted and a
// forked monitor checks each launched p_data against the queue on every send toggle.
module tb_sd_to_apc;
    localparam int W = 32;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    sd_to_apc_if #(.width(W)) bif ();

    sd_to_apc #(.width(W)) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bif)
    );

    int             tests = 0;
    int             fails = 0;
    logic [W-1:0]   exp_q[$];
    int             n_toggles = 0;
    bit             inflight = 1'b0;
    bit             saw_drdy_low = 1'b0;
    int             stab_viol = 0;
    bit             rx_auto = 1'b1;
    int             rx_delay = 5;
    int             spur_req = 0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, required %0h", name, act, req);
        end else begin
            $display("[TB] ok   %s = %0h", name, act);
        end
    endtask

    // Far-side receiver: mirrors p_ph_send after rx_delay cycles, or toggles on request.
    task automatic receiver();
        int cnt  = 0;
        int seen = 0;
        bif.p_ph_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                bif.p_ph_ack = 1'b0;
                cnt  = 0;
                seen = spur_req;
            end else if (seen != spur_req) begin
                bif.p_ph_ack = ~bif.p_ph_ack;
                seen++;
            end else if (rx_auto && (bif.p_ph_send !== bif.p_ph_ack)) begin
                cnt++;
                if (cnt >= rx_delay) begin
                    bif.p_ph_ack = bif.p_ph_send;
                    cnt = 0;
                end
            end else begin
                cnt = 0;
            end
        end
    endtask

    task automatic monitor();
        logic         ps = 1'b0;
        logic         pa = 1'b0;
        logic [W-1:0] pd = '0;
        logic [W-1:0] e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if ((bif.p_data !== pd) && inflight) stab_viol++;
                if (!bif.c_drdy) saw_drdy_low = 1'b1;
                if (bif.p_ph_send !== ps) begin
                    n_toggles++;
                    if (exp_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("[TB] FAIL launch_unexpected: got p_data %0h, required no launch", bif.p_data);
                    end else begin
                        e = exp_q.pop_front();
                        check("launch_data", bif.p_data, e);
                    end
                    inflight = 1'b1;
                end else if (bif.p_ph_ack !== pa) begin
                    inflight = 1'b0;
                end
            end else begin
                inflight = 1'b0;
            end
            ps = bif.p_ph_send;
            pa = bif.p_ph_ack;
            pd = bif.p_data;
        end
    endtask

    // Presents w until accepted; returns just after the accepting edge with c_srdy still high.
    task automatic push(input logic [W-1:0] w);
        int guard = 0;
        @(negedge clk);
        bif.c_srdy = 1'b1;
        bif.c_data = w;
        while (!bif.c_drdy && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 500) begin
            tests++;
            fails++;
            $display("[TB] FAIL push_timeout: got c_drdy 0, required 1 for word %0h", w);
            bif.c_srdy = 1'b0;
        end else begin
            exp_q.push_back(w);
            $display("[TB] push %0h", w);
            @(posedge clk);
        end
    endtask

    task automatic srdy_off();
        @(negedge clk);
        bif.c_srdy = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        bif.c_srdy = 1'b0;
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_drain(input string name);
        int guard = 0;
        while ((exp_q.size() != 0 || inflight) && guard < 600) begin
            @(negedge clk);
            guard++;
        end
        repeat (8) @(negedge clk);
        check({"drain_", name}, exp_q.size(), 0);
    endtask

    task automatic wait_toggles(input string name, input int target);
        int guard = 0;
        while (n_toggles < target && guard < 60) begin
            @(negedge clk);
            guard++;
        end
        check(name, n_toggles, target);
    endtask

    initial begin
        int t0;
        int viol;
        logic [W-1:0] hold_d;
        logic         hold_s;

        bif.c_srdy = 1'b0;
        bif.c_data = '0;
        fork
            receiver();
            monitor();
        join_none

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_c_drdy", bif.c_drdy, 1);
        check("rst_p_ph_send", bif.p_ph_send, 0);
        check("rst_p_data", bif.p_data, 0);
        rst_n = 1'b1;
        check("drdy_after_reset", bif.c_drdy, 1);

        // Single word: p_data two cycles after acceptance, send toggle one later
        push(32'hDEADBEEF);
        @(negedge clk);
        bif.c_srdy = 1'b0;
        check("single_pdata_n1", bif.p_data, 0);
        @(negedge clk);
        check("single_pdata_n2", bif.p_data, 32'hDEADBEEF);
        check("single_send_n2", bif.p_ph_send, 0);
        @(negedge clk);
        check("single_send_n3", bif.p_ph_send, 1);
        wait_drain("single");
        check("single_toggles", n_toggles, 1);
        check("single_drdy_idle", bif.c_drdy, 1);

        // Back-to-back with c_srdy held high
        do_reset();
        t0 = n_toggles;
        saw_drdy_low = 1'b0;
        for (int i = 1; i <= 4; i++) push(i);
        srdy_off();
        wait_drain("b2b");
        check("b2b_toggles", n_toggles - t0, 4);
        check("b2b_send_end", bif.p_ph_send, 0);
        check("b2b_drdy_dropped", saw_drdy_low, 1);

        // Refill-on-drain: 3 accepted on the same edge that moves 2 into p_data
        do_reset();
        t0 = n_toggles;
        push(32'h1);
        push(32'h2);
        push(32'h3);
        #1;
        check("refill_pdata", bif.p_data, 32'h2);
        check("refill_pend_full", bif.c_drdy, 0);
        srdy_off();
        wait_drain("refill");
        check("refill_toggles", n_toggles - t0, 3);

        // Slow ack: nothing moves for 100 cycles while the ack is withheld
        do_reset();
        rx_auto = 1'b0;
        t0 = n_toggles;
        push(32'hA1);
        push(32'hA2);
        srdy_off();
        wait_toggles("slow_launch", t0 + 1);
        hold_d = bif.p_data;
        hold_s = bif.p_ph_send;
        viol = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bif.p_data !== hold_d || bif.p_ph_send !== hold_s || bif.c_drdy !== 1'b0) viol++;
        end
        check("slow_hold_violations", viol, 0);
        rx_auto = 1'b1;
        wait_drain("slow");
        check("slow_toggles", n_toggles - t0, 2);

        // Spurious ack in idle must not complete the next word
        do_reset();
        rx_auto = 1'b0;
        repeat (3) @(negedge clk);
        spur_req++;
        repeat (10) @(negedge clk);
        t0 = n_toggles;
        push(32'h5A);
        push(32'h5B);
        srdy_off();
        repeat (20) @(negedge clk);
        check("spur_one_launch", n_toggles - t0, 1);
        check("spur_pdata_held", bif.p_data, 32'h5A);
        spur_req++;
        wait_toggles("spur_fresh_ack", t0 + 2);
        spur_req++;
        wait_drain("spur");

        // Reset while a word is in flight and another is pending
        do_reset();
        rx_auto = 1'b0;
        t0 = n_toggles;
        push(32'hB1);
        push(32'hB2);
        srdy_off();
        wait_toggles("midrst_launch", t0 + 1);
        repeat (3) @(negedge clk);
        check("midrst_full_before", bif.c_drdy, 0);
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("midrst_drdy_in_reset", bif.c_drdy, 1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst_send", bif.p_ph_send, 0);
        check("midrst_drdy", bif.c_drdy, 1);
        t0 = n_toggles;
        repeat (10) @(negedge clk);
        check("midrst_no_toggle", n_toggles - t0, 0);
        rx_auto = 1'b1;
        push(32'hC3);
        srdy_off();
        wait_drain("midrst");
        check("midrst_next_word", n_toggles - t0, 1);

        check("pdata_stability_violations", stab_viol, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/sd_to_apc.md
Name: sd_to_apc

Overview:
- Transmit end of the async phase-change (APC) interface.
- Accepts words on a srdy/drdy consumer port and launches each word across the clock boundary.
- Data is held stable on p_data, then p_ph_send is toggled once per word.
- The next word is not launched until the far side toggles p_ph_ack.
- A one-entry holding register lets the upstream hand off the next word while the current one is in flight.

Parameters:
width, 32, data word width in bits

Ports:
clk  input  1  block clock
reset  input  1  reset; synchronous, active-low; asserted when 0, sampled on rising clk
c_srdy  input  1  upstream word valid
c_drdy  output  1  block can accept a word this cycle
c_data  input  width  upstream word
p_ph_send  output  1  phase-change send; toggles once per launched word
p_ph_ack  input  1  phase-change ack from the far domain; asynchronous to clk
p_data  output  width  launched word; stable from launch until the matching ack is detected

Behaviour:
- Ack sync: p_ph_ack → xp_synchronizer (width 1) → sync_ack; dly_ack <= sync_ack every cycle; ack_edge = sync_ack ^ dly_ack.
- Holding register: pend_data / pend_valid.
  - c_drdy = !pend_valid || (state == s_idle).
  - Transfer occurs when c_srdy && c_drdy; c_data is written into pend_data and pend_valid is set.
- FSM states: s_idle, s_setup, s_wait.
  - s_idle: if pend_valid, then p_data <= pend_data, pend_valid cleared (unless refilled the same cycle), next state s_setup. Otherwise stay in s_idle.
  - s_setup: p_ph_send <= ~p_ph_send; next state s_wait. This gives one full clk cycle of p_data setup before the send edge.
  - s_wait: hold p_data and p_ph_send. On ack_edge, next state s_idle; otherwise stay.
- Simultaneous events: in s_idle with pend_valid and c_srdy, the pend word moves to p_data and the new word is written to pend in the same cycle, so pend_valid stays 1.
- Full: while pend_valid and state != s_idle, c_drdy = 0. c_data/c_srdy are ignored except when a transfer occurs.
- Latency:
  - Word accepted into empty pend at cycle N with state s_idle: p_data updated at N+2; p_ph_send toggles at N+3.
  - Minimum per-word period: 3 cycles plus ack round trip (synchronizer depth + 1 cycle for edge detection).
- ack_edge outside s_wait (protocol violation) is ignored. dly_ack still tracks sync_ack, so the stray edge is consumed and not replayed later.
- Only one transfer is outstanding at a time: at most 1 word in p_data awaiting ack, plus 1 in pend.
- Reset values:
  - state = s_idle, pend_valid = 0, p_ph_send = 0, dly_ack = 0, p_data = 0.
  - c_drdy = 1 during reset and in the first cycle after it.
- Reset mid-operation:
  - Any pending or in-flight word is discarded; p_ph_send returns to 0.
  - The far-end receiver must be reset in the same window so its ack phase also returns to 0. Otherwise the first post-reset ack edge is misinterpreted. This is a system-level requirement, not checked by this block.
- Phase values are meaningful only as toggles. Absolute level of p_ph_send vs p_ph_ack carries no information beyond their equality at rest.

Test Plan:
- Single word: after reset, c_srdy=1 with c_data=32'hDEADBEEF for 1 cycle. Required: p_data=DEADBEEF two cycles later, p_ph_send 0→1 one cycle after that. Bench toggles p_ph_ack 0→1 → state returns to s_idle once the sync delay plus 1 cycle has elapsed, with no further send toggle.
- Back-to-back: drive 4 words 1,2,3,4 with c_srdy held high; bench acks each toggle after 5 cycles. Required:
  - c_drdy drops while pend is full and a word is in flight.
  - p_ph_send toggles exactly 4 times, ending at 0.
  - p_data sequence is 1,2,3,4.
  - Each p_data value is stable from update until its ack edge is observed.
- Refill-on-drain: pend holds 2 and the FSM enters s_idle as c_srdy presents 3. Required: 2 loaded to p_data and 3 captured into pend in the same cycle; c_drdy=1 that cycle; no word lost or duplicated.
- Slow ack: bench withholds ack for 100 cycles after the send toggle. Required: p_data and p_ph_send unchanged for all 100 cycles; c_drdy=0 once pend fills.
- Spurious ack: toggle p_ph_ack while in s_idle with no pending data, then send word 8'h5A. Required: the stray edge is ignored; word 5A waits in s_wait for a fresh ack toggle rather than completing immediately.
- Reset mid-flight: assert reset (0) for 2 cycles while in s_wait with pend_valid=1, resetting the bench receiver too. Required: p_ph_send=0, c_drdy=1, no send toggle on release; the next word transfers normally.
